// File: rtl/servant_ram_arb.sv
// Round-robin two-master Wishbone arbiter in front of the single-port servant_ram.
// Optional bus-hang watchdog enabled by defining SERVANT_ARB_TIMEOUT_EN.
module servant_ram_arb #(
    parameter int AW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,

    input  logic [AW-1:0] i_m0_adr,
    input  logic [31:0]   i_m0_dat,
    input  logic [3:0]    i_m0_sel,
    input  logic          i_m0_we,
    input  logic          i_m0_stb,
    output logic [31:0]   o_m0_rdt,
    output logic          o_m0_ack,

    input  logic [AW-1:0] i_m1_adr,
    input  logic [31:0]   i_m1_dat,
    input  logic [3:0]    i_m1_sel,
    input  logic          i_m1_we,
    input  logic          i_m1_stb,
    output logic [31:0]   o_m1_rdt,
    output logic          o_m1_ack,

    output logic [AW-1:0] o_s_adr,
    output logic [31:0]   o_s_dat,
    output logic [3:0]    o_s_sel,
    output logic          o_s_we,
    output logic          o_s_cyc,
    input  logic [31:0]   i_s_rdt,
    input  logic          i_s_ack,

    output logic [1:0]    o_grant,
    output logic          o_timeout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t     r_state;
    logic       r_last;
    logic [1:0] r_grant;

    logic w_busy0;
    logic w_busy1;
    logic w_ack0;
    logic w_ack1;
    logic w_limit;
    logic w_to0;
    logic w_to1;

    assign w_busy0 = (r_state == BUSY0);
    assign w_busy1 = (r_state == BUSY1);

    // A slave ack only counts while the granted master still holds its request.
    assign w_ack0 = i_s_ack & w_busy0 & i_m0_stb;
    assign w_ack1 = i_s_ack & w_busy1 & i_m1_stb;

`ifdef SERVANT_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    // Counter sits at zero while idle, so every grant starts its watchdog fresh.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_cnt <= '0;
        end else if (!i_s_ack) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign w_limit = (r_cnt == CW'(TIMEOUT - 1));
`else
    // Watchdog compiled out: the limit is never reached.
    assign w_limit = 1'b0 && (TIMEOUT > 0);
`endif

    assign w_to0 = w_busy0 & i_m0_stb & ~i_s_ack & w_limit;
    assign w_to1 = w_busy1 & i_m1_stb & ~i_s_ack & w_limit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_grant <= 2'b00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_m0_stb && (!i_m1_stb || r_last)) begin
                        r_state <= BUSY0;
                        r_grant <= 2'b01;
                    end else if (i_m1_stb) begin
                        r_state <= BUSY1;
                        r_grant <= 2'b10;
                    end
                end
                BUSY0: begin
                    if (!i_m0_stb) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end else if (w_ack0 || w_to0) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                        r_last  <= 1'b0;
                    end
                end
                BUSY1: begin
                    if (!i_m1_stb) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                    end else if (w_ack1 || w_to1) begin
                        r_state <= IDLE;
                        r_grant <= 2'b00;
                        r_last  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_grant <= 2'b00;
                end
            endcase
        end
    end

    // Master 0 owns the slave address/data lines whenever master 1 is not granted.
    assign o_s_adr = w_busy1 ? i_m1_adr : i_m0_adr;
    assign o_s_dat = w_busy1 ? i_m1_dat : i_m0_dat;
    assign o_s_sel = w_busy1 ? i_m1_sel : i_m0_sel;
    assign o_s_we  = w_busy1 ? i_m1_we  : i_m0_we;
    assign o_s_cyc = (w_busy0 & i_m0_stb & ~w_to0) | (w_busy1 & i_m1_stb & ~w_to1);

    assign o_m0_ack  = w_ack0 | w_to0;
    assign o_m1_ack  = w_ack1 | w_to1;
    assign o_m0_rdt  = (w_busy0 && !w_to0) ? i_s_rdt : 32'd0;
    assign o_m1_rdt  = (w_busy1 && !w_to1) ? i_s_rdt : 32'd0;
    assign o_grant   = r_grant;
    assign o_timeout = w_to0 | w_to1;

endmodule

// File: tb/tb_servant_ram_arb.sv
// Self-checking bench for servant_ram_arb: directed scenarios followed by random
// two-master traffic against a shadow-memory and fairness model.
module tb_servant_ram_arb;

    localparam int TIMEOUT = 8;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [31:0] i_m0_adr, i_m0_dat, i_m1_adr, i_m1_dat;
    logic [3:0]  i_m0_sel, i_m1_sel;
    logic        i_m0_we, i_m0_stb, i_m1_we, i_m1_stb;
    logic [31:0] o_m0_rdt, o_m1_rdt;
    logic        o_m0_ack, o_m1_ack;
    logic [31:0] o_s_adr, o_s_dat;
    logic [3:0]  o_s_sel;
    logic        o_s_we, o_s_cyc;
    logic [31:0] i_s_rdt;
    logic        i_s_ack;
    logic [1:0]  o_grant;
    logic        o_timeout;

    int checks = 0;
    int errors = 0;

    servant_ram_arb #(.AW(32), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_adr(i_m0_adr), .i_m0_dat(i_m0_dat), .i_m0_sel(i_m0_sel),
        .i_m0_we(i_m0_we), .i_m0_stb(i_m0_stb), .o_m0_rdt(o_m0_rdt), .o_m0_ack(o_m0_ack),
        .i_m1_adr(i_m1_adr), .i_m1_dat(i_m1_dat), .i_m1_sel(i_m1_sel),
        .i_m1_we(i_m1_we), .i_m1_stb(i_m1_stb), .o_m1_rdt(o_m1_rdt), .o_m1_ack(o_m1_ack),
        .o_s_adr(o_s_adr), .o_s_dat(o_s_dat), .o_s_sel(o_s_sel), .o_s_we(o_s_we),
        .o_s_cyc(o_s_cyc), .i_s_rdt(i_s_rdt), .i_s_ack(i_s_ack),
        .o_grant(o_grant), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    // Slave model: registered ack after sLatency cycles of cyc, like servant_ram.
    logic [31:0] sMem [16];
    logic [31:0] sRdt = 32'd0;
    logic        sAck = 1'b0;
    int          sCnt = 0;
    int          sLatency = 1;
    bit          sSilent = 1'b0;
    bit          sStray = 1'b0;
    bit          memClear = 1'b0;

    always @(posedge i_clk) begin
        if (memClear) begin
            for (int i = 0; i < 16; i++) sMem[i] <= 32'd0;
        end
        if (sStray) begin
            sAck <= 1'b1;
        end else if (o_s_cyc && !sAck && !sSilent) begin
            if (sCnt + 1 >= sLatency) begin
                sAck <= 1'b1;
                sCnt <= 0;
                sRdt <= sMem[o_s_adr[5:2]];
                if (o_s_we) begin
                    for (int b = 0; b < 4; b++)
                        if (o_s_sel[b]) sMem[o_s_adr[5:2]][8*b +: 8] <= o_s_dat[8*b +: 8];
                end
            end else begin
                sCnt <= sCnt + 1;
            end
        end else begin
            sAck <= 1'b0;
            sCnt <= 0;
        end
    end

    assign i_s_ack = sAck;
    assign i_s_rdt = sSilent ? 32'hDEADBEEF : sRdt;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic applyStimulus(input int n, input logic stb, input logic we,
                                 input logic [31:0] adr, input logic [31:0] dat,
                                 input logic [3:0] sel);
        if (n == 0) begin
            i_m0_stb = stb; i_m0_we = we; i_m0_adr = adr; i_m0_dat = dat; i_m0_sel = sel;
        end else begin
            i_m1_stb = stb; i_m1_we = we; i_m1_adr = adr; i_m1_dat = dat; i_m1_sel = sel;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        i_rst_n = 1'b0;
        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        step();
        step();
        i_rst_n = 1'b1;
        #1;
    endtask

    // Random-phase model state
    logic [31:0] shadow [16];
    logic        mAct [2];
    logic        mWe [2];
    logic [31:0] mAdr [2];
    logic [31:0] mDat [2];
    logic [3:0]  mSel [2];
    int          mAge [2];
    int          mPass [2];

    initial begin
        int nAck;
        bit expectIdle;
        int owner;
        logic ack;
        logic [31:0] rdt;
        int word;

        applyStimulus(0, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'd0, 32'd0, 4'h0);

        // Reset values
        i_rst_n = 1'b0;
        memClear = 1'b1;
        repeat (3) step();
        memClear = 1'b0;
        checkOutput("reset s_cyc", o_s_cyc, 0);
        checkOutput("reset grant", o_grant, 0);
        checkOutput("reset m0_ack", o_m0_ack, 0);
        checkOutput("reset m1_ack", o_m1_ack, 0);
        checkOutput("reset m0_rdt", o_m0_rdt, 0);
        checkOutput("reset m1_rdt", o_m1_rdt, 0);
        checkOutput("reset timeout", o_timeout, 0);
        i_rst_n = 1'b1;

        // m0 alone: write 0x12345678 to 0x10, then read it back
        step();
        applyStimulus(0, 1'b1, 1'b1, 32'h10, 32'h12345678, 4'hF);
        #1;
        checkOutput("t1 arbitration latency", o_grant, 2'b00);
        step();
        checkOutput("t1 grant", o_grant, 2'b01);
        checkOutput("t1 s_adr", o_s_adr, 32'h10);
        checkOutput("t1 s_cyc", o_s_cyc, 1);
        step();
        checkOutput("t1 write ack", o_m0_ack, 1);
        step();
        applyStimulus(0, 1'b1, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        checkOutput("t1 forced idle", o_grant, 2'b00);
        step();
        checkOutput("t1 read grant", o_grant, 2'b01);
        step();
        checkOutput("t1 read ack", o_m0_ack, 1);
        checkOutput("t1 read rdt", o_m0_rdt, 32'h12345678);
        checkOutput("t1 m1_ack", o_m1_ack, 0);
        step();
        applyStimulus(0, 1'b0, 1'b0, 32'h10, 32'h0, 4'hF);
        #1;
        checkOutput("t1 back to idle", o_grant, 2'b00);
        checkOutput("t1 cyc low", o_s_cyc, 0);

        // Simultaneous request after reset: m0 first, then m1's write
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h11111111, 4'h3);
        applyStimulus(1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
        #1;
        step();
        checkOutput("t2 first grant", o_grant, 2'b01);
        checkOutput("t2 s_dat m0", o_s_dat, 32'h11111111);
        checkOutput("t2 s_sel m0", o_s_sel, 4'h3);
        step();
        checkOutput("t2 m0_ack", o_m0_ack, 1);
        checkOutput("t2 m1 no ack", o_m1_ack, 0);
        step();
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h11111111, 4'h3);
        #1;
        checkOutput("t2 idle grant", o_grant, 2'b00);
        checkOutput("t2 idle s_dat", o_s_dat, 32'h11111111);
        step();
        checkOutput("t2 second grant", o_grant, 2'b10);
        checkOutput("t2 s_dat m1", o_s_dat, 32'hA5A5A5A5);
        checkOutput("t2 s_sel m1", o_s_sel, 4'hF);
        checkOutput("t2 s_adr m1", o_s_adr, 32'h20);
        checkOutput("t2 s_we m1", o_s_we, 1);
        step();
        checkOutput("t2 m1_ack", o_m1_ack, 1);
        checkOutput("t2 m0 no ack", o_m0_ack, 0);
        step();
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // Both held: four transactions alternate m0,m1,m0,m1 with an idle gap
        doReset();
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        nAck = 0;
        expectIdle = 1'b0;
        for (int c = 0; c < 40 && (nAck < 4 || expectIdle); c++) begin
            step();
            if (expectIdle) begin
                checkOutput("t3 idle gap", o_grant, 2'b00);
                expectIdle = 1'b0;
            end else if (o_m0_ack || o_m1_ack) begin
                owner = o_m1_ack ? 1 : 0;
                checkOutput($sformatf("t3 order #%0d", nAck), owner, nAck % 2);
                nAck++;
                expectIdle = 1'b1;
            end
        end
        checkOutput("t3 transaction count", nAck, 4);
        applyStimulus(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        applyStimulus(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

        // m1 aborts one cycle into its grant; stray ack must not reach it
        doReset();
        sLatency = 3;
        applyStimulus(1, 1'b1, 1'b0, 32'h8, 32'h0, 4'hF);
        #1;
        step();
        checkOutput("t4 grant m1", o_grant, 2'b10);
        step();
        applyStimulus(1, 1'b0, 1'b0, 32'h8, 32'h0, 4'hF);
        #1;
        checkOutput("t4 abort cycle ack", o_m1_ack, 0);
        step();
        checkOutput("t4 idle after abort", o_grant, 2'b00);
        sStray = 1'b1;
        step();
        sStray = 1'b0;
        checkOutput("t4 stray ack m1", o_m1_ack, 0);
        checkOutput("t4 stray ack m0", o_m0_ack, 0);
        applyStimulus(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
        applyStimulus(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        #1;
        step();
        checkOutput("t4 last unchanged", o_grant, 2'b01);

        // Async reset mid-BUSY0
        i_rst_n = 1'b0;
        #1;
        checkOutput("t5 reset s_cyc", o_s_cyc, 0);
        checkOutput("t5 reset grant", o_grant, 2'b00);
        checkOutput("t5 reset m0_ack", o_m0_ack, 0);
        step();
        i_rst_n = 1'b1;
        #1;
        step();
        checkOutput("t5 m0 first after reset", o_grant, 2'b01);
        doReset();
        sLatency = 1;

`ifdef SERVANT_ARB_TIMEOUT_EN
        // Silent slave: watchdog fires on the TIMEOUT-th busy cycle
        sSilent = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
        #1;
        for (int i = 1; i <= TIMEOUT; i++) begin
            step();
            if (i < TIMEOUT) begin
                checkOutput($sformatf("t6 wait ack %0d", i), o_m0_ack, 0);
                checkOutput($sformatf("t6 wait timeout %0d", i), o_timeout, 0);
            end else begin
                checkOutput("t6 timeout ack", o_m0_ack, 1);
                checkOutput("t6 timeout rdt", o_m0_rdt, 0);
                checkOutput("t6 timeout pulse", o_timeout, 1);
                checkOutput("t6 timeout cyc", o_s_cyc, 0);
            end
        end
        step();
        applyStimulus(0, 1'b0, 1'b0, 32'h4, 32'h0, 4'hF);
        #1;
        checkOutput("t6 idle after timeout", o_grant, 2'b00);
        checkOutput("t6 pulse ended", o_timeout, 0);
        sSilent = 1'b0;
        doReset();
`endif

        // Random two-master traffic against the shadow memory
        memClear = 1'b1;
        step();
        memClear = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 32'd0;
        for (int n = 0; n < 2; n++) begin
            mAct[n] = 1'b0; mWe[n] = 1'b0; mAdr[n] = 32'd0; mDat[n] = 32'd0;
            mSel[n] = 4'h0; mAge[n] = 0; mPass[n] = 0;
        end
        doReset();
        for (int c = 0; c < 600; c++) begin
            step();
            if (!mAct[0] && !mAct[1]) sLatency = $urandom_range(1, 3);
            for (int n = 0; n < 2; n++) begin
                if (!mAct[n] && $urandom_range(0, 2) == 0) begin
                    mAct[n]  = 1'b1;
                    mWe[n]   = 1'($urandom_range(0, 1));
                    mAdr[n]  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
                    mDat[n]  = $urandom;
                    mSel[n]  = 4'($urandom_range(0, 15));
                    mAge[n]  = 0;
                    mPass[n] = 0;
                end
                applyStimulus(n, mAct[n], mWe[n], mAdr[n], mDat[n], mSel[n]);
            end
            #1;
            for (int n = 0; n < 2; n++) begin
                ack = (n == 0) ? o_m0_ack : o_m1_ack;
                rdt = (n == 0) ? o_m0_rdt : o_m1_rdt;
                if (!mAct[n]) begin
                    if (ack) checkOutput($sformatf("rnd m%0d spurious ack", n), ack, 0);
                end else if (ack) begin
                    word = int'(mAdr[n][5:2]);
                    if (mWe[n]) begin
                        for (int b = 0; b < 4; b++)
                            if (mSel[n][b]) shadow[word][8*b +: 8] = mDat[n][8*b +: 8];
                    end else begin
                        checkOutput($sformatf("rnd m%0d read @%h", n, mAdr[n]), rdt, shadow[word]);
                    end
                    checkOutput("rnd timeout idle", o_timeout, 0);
                    mAct[n] = 1'b0;
                    if (mAct[1-n]) begin
                        mPass[1-n]++;
                        checkOutput($sformatf("rnd m%0d fairness", 1-n), (mPass[1-n] <= 1), 1);
                    end
                end else begin
                    mAge[n]++;
                    if (mAge[n] >= 40) begin
                        checkOutput($sformatf("rnd m%0d stalled", n), 0, 1);
                        mAct[n] = 1'b0;
                    end
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
